// File: rtl/dma_bench_pkg.sv
// Shared types and defaults for the DMA throughput benchmark sequencer.
package dma_bench_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int DEF_N_ITER  = 4;
    localparam int DEF_TIMEOUT = 100;
    localparam int DEF_CNT_W   = 32;

    localparam logic [DEF_CNT_W-1:0] STAT_MIN_INIT = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/dma_bench_ctrl_latency_stats.sv
// Last/min/max/saturating-sum latency statistics, cleared at the start of each run.
module latency_stats
    import dma_bench_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [CNT_W-1:0] sample,
    output logic [CNT_W-1:0] tim_last,
    output logic [CNT_W-1:0] tim_min,
    output logic [CNT_W-1:0] tim_max,
    output logic [CNT_W-1:0] tim_sum
);

    localparam logic [CNT_W-1:0] MIN_INIT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        logic [CNT_W:0] w_full;
        w_full = {1'b0, a} + {1'b0, b};
        sat_add = w_full[CNT_W] ? MIN_INIT : w_full[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] r_last;
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_sum;

    // statistic registers: reset/clear to empty-run values, fold in each accepted sample
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_last <= ZERO;
            r_min  <= MIN_INIT;
            r_max  <= ZERO;
            r_sum  <= ZERO;
        end else if (sample_valid) begin
            r_last <= sample;
            r_min  <= (sample < r_min) ? sample : r_min;
            r_max  <= (sample > r_max) ? sample : r_max;
            r_sum  <= sat_add(r_sum, sample);
        end else begin
            r_last <= r_last;
            r_min  <= r_min;
            r_max  <= r_max;
            r_sum  <= r_sum;
        end
    end

    assign tim_last = r_last;
    assign tim_min  = r_min;
    assign tim_max  = r_max;
    assign tim_sum  = r_sum;

endmodule

// File: rtl/dma_bench_ctrl.sv
// Benchmark sequencer: launches N_ITER DMA transfers, times each go-to-done
// latency under a timeout guard and accumulates run statistics.
module dma_bench_ctrl
    import dma_bench_pkg::*;
#(
    parameter int N_ITER  = DEF_N_ITER,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dma_go,
    input  logic             dma_done,
    output logic             busy,
    output logic             finish,
    output logic             timeout,
    output logic [7:0]       runs_done,
    output logic [CNT_W-1:0] tim_last,
    output logic [CNT_W-1:0] tim_min,
    output logic [CNT_W-1:0] tim_max,
    output logic [CNT_W-1:0] tim_sum
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [7:0]       N_ITER_C  = 8'(N_ITER);
    localparam logic [CNT_W-1:0] LAT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAT_ZERO  = {CNT_W{1'b0}};

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_lat;
    logic [CNT_W-1:0] w_lat_cur;
    logic [7:0]       r_runs;
    logic             r_go;
    logic             r_busy;
    logic             r_finish;
    logic             r_timeout;
    logic             w_accept_start;
    logic             w_sample;
    logic             w_abort;

    // next-state decode; w_lat_cur is the counter value seen in the current WAIT cycle
    always_comb begin
        w_next         = r_state;
        w_accept_start = 1'b0;
        w_sample       = 1'b0;
        w_abort        = 1'b0;
        w_lat_cur      = r_lat + LAT_ONE;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept_start = 1'b1;
                    w_next         = ST_LAUNCH;
                end else begin
                    w_next = r_state;
                end
            end
            ST_LAUNCH: w_next = ST_WAIT;
            ST_WAIT: begin
                // a completion in the timeout cycle still counts as a sample
                if (dma_done) begin
                    w_sample = 1'b1;
                    w_next   = ST_GAP;
                end else if (w_lat_cur == TIMEOUT_C) begin
                    w_abort = 1'b1;
                    w_next  = ST_DONE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (r_runs == N_ITER_C) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_LAUNCH;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // state register and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_go    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_go    <= (w_next == ST_LAUNCH);
            r_busy  <= (w_next == ST_LAUNCH) || (w_next == ST_WAIT) || (w_next == ST_GAP);
        end
    end

    // latency counter and run bookkeeping (iteration count doubles as runs_done)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat     <= LAT_ZERO;
            r_runs    <= 8'd0;
            r_finish  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_LAUNCH) begin
                r_lat <= LAT_ZERO;
            end else if (r_state == ST_WAIT) begin
                r_lat <= w_lat_cur;
            end else begin
                r_lat <= r_lat;
            end
            if (w_accept_start) begin
                r_finish  <= 1'b0;
                r_timeout <= 1'b0;
                r_runs    <= 8'd0;
            end else begin
                r_finish  <= r_finish | (w_next == ST_DONE);
                r_timeout <= r_timeout | w_abort;
                r_runs    <= w_sample ? (r_runs + 8'd1) : r_runs;
            end
        end
    end

    latency_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .clear        (w_accept_start),
        .sample_valid (w_sample),
        .sample       (w_lat_cur),
        .tim_last     (tim_last),
        .tim_min      (tim_min),
        .tim_max      (tim_max),
        .tim_sum      (tim_sum)
    );

    assign dma_go    = r_go;
    assign busy      = r_busy;
    assign finish    = r_finish;
    assign timeout   = r_timeout;
    assign runs_done = r_runs;

endmodule

// File: tb/tb_dma_bench_ctrl.sv
// Self-checking bench for dma_bench_ctrl: a DMA responder plays per-transfer delays,
// and a run-level model derives the expected statistics from those delays.
module tb_dma_bench_ctrl;

    localparam int N_ITER  = 4;
    localparam int TIMEOUT = 100;
    localparam int CNT_W   = 32;
    localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             dma_done;
    logic             dma_go;
    logic             busy;
    logic             finish;
    logic             timeout;
    logic [7:0]       runs_done;
    logic [CNT_W-1:0] tim_last;
    logic [CNT_W-1:0] tim_min;
    logic [CNT_W-1:0] tim_max;
    logic [CNT_W-1:0] tim_sum;

    int n_checks = 0;
    int n_pass   = 0;
    int go_cnt   = 0;
    int dly [N_ITER];

    dma_bench_ctrl #(.N_ITER(N_ITER), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dma_go    (dma_go),
        .dma_done  (dma_done),
        .busy      (busy),
        .finish    (finish),
        .timeout   (timeout),
        .runs_done (runs_done),
        .tim_last  (tim_last),
        .tim_min   (tim_min),
        .tim_max   (tim_max),
        .tim_sum   (tim_sum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dma_go === 1'b1) go_cnt = go_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dly(input int a, input int b, input int c, input int d);
        dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
    endtask

    // Delays above TIMEOUT mean "the DMA never answers this transfer".
    task automatic model(output int e_runs, output logic [CNT_W-1:0] e_last,
                         output logic [CNT_W-1:0] e_min, output logic [CNT_W-1:0] e_max,
                         output logic [CNT_W-1:0] e_sum, output bit e_to, output int e_go);
        int     q[$];
        longint s;
        e_to = 1'b0;
        e_go = 0;
        for (int i = 0; i < N_ITER; i++) begin
            e_go++;
            if (dly[i] > TIMEOUT) begin
                e_to = 1'b1;
                break;
            end
            q.push_back(dly[i]);
        end
        e_runs = q.size();
        e_last = '0;
        e_min  = ONES;
        e_max  = '0;
        s      = 0;
        foreach (q[k]) begin
            s += q[k];
            if (CNT_W'(q[k]) < e_min) e_min = CNT_W'(q[k]);
            if (CNT_W'(q[k]) > e_max) e_max = CNT_W'(q[k]);
        end
        if (q.size() > 0) e_last = CNT_W'(q[q.size()-1]);
        e_sum = (s > longint'(ONES)) ? ONES : CNT_W'(s);
    endtask

    // One full run using dly[]; noise adds start-while-busy and dma_done in GAP/DONE.
    task automatic run_check(input string tag, input bit noise);
        logic [CNT_W-1:0] e_last, e_min, e_max, e_sum;
        int e_runs, e_go, go_base, budget;
        bit e_to, stop;
        model(e_runs, e_last, e_min, e_max, e_sum, e_to, e_go);
        go_base = go_cnt;
        stop = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N_ITER && !stop; i++) begin
            budget = 10;
            while (dma_go !== 1'b1 && budget > 0) begin
                step();
                budget--;
            end
            n_checks++;
            if (dma_go !== 1'b1) begin
                $display("FAIL %s go_wait[%0d]: dma_go=%b, required 1 within 10 cycles", tag, i, dma_go);
                stop = 1'b1;
            end else begin
                n_pass++;
                if (noise) start = 1'b1;
                if (dly[i] > TIMEOUT) begin
                    for (int j = 0; j < TIMEOUT; j++) begin
                        step();
                        start = 1'b0;
                    end
                    n_checks++;
                    if (timeout !== 1'b0 || busy !== 1'b1)
                        $display("FAIL %s to_early: timeout=%b busy=%b, required 0/1", tag, timeout, busy);
                    else n_pass++;
                    step();
                    n_checks++;
                    if (timeout !== 1'b1 || finish !== 1'b1 || busy !== 1'b0)
                        $display("FAIL %s to_edge: timeout=%b finish=%b busy=%b, required 1/1/0", tag, timeout, finish, busy);
                    else n_pass++;
                    stop = 1'b1;
                end else begin
                    for (int j = 0; j < dly[i]; j++) begin
                        step();
                        start = 1'b0;
                    end
                    dma_done = 1'b1;
                    step();
                    if (noise) step();
                    dma_done = 1'b0;
                end
            end
        end
        budget = 10;
        while (finish !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        if (noise) begin
            dma_done = 1'b1;
            step();
            step();
            dma_done = 1'b0;
            step();
        end
        n_checks++;
        if (runs_done !== 8'(e_runs)) $display("FAIL %s runs_done: got %0d, required %0d", tag, runs_done, e_runs);
        else n_pass++;
        n_checks++;
        if (tim_last !== e_last) $display("FAIL %s tim_last: got %0d, required %0d", tag, tim_last, e_last);
        else n_pass++;
        n_checks++;
        if (tim_min !== e_min) $display("FAIL %s tim_min: got %0h, required %0h", tag, tim_min, e_min);
        else n_pass++;
        n_checks++;
        if (tim_max !== e_max) $display("FAIL %s tim_max: got %0d, required %0d", tag, tim_max, e_max);
        else n_pass++;
        n_checks++;
        if (tim_sum !== e_sum) $display("FAIL %s tim_sum: got %0d, required %0d", tag, tim_sum, e_sum);
        else n_pass++;
        n_checks++;
        if (finish !== 1'b1 || busy !== 1'b0) $display("FAIL %s finish/busy: got %b/%b, required 1/0", tag, finish, busy);
        else n_pass++;
        n_checks++;
        if (timeout !== e_to) $display("FAIL %s timeout: got %b, required %b", tag, timeout, e_to);
        else n_pass++;
        n_checks++;
        if (go_cnt - go_base !== e_go) $display("FAIL %s go_count: got %0d, required %0d", tag, go_cnt - go_base, e_go);
        else n_pass++;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (dma_go !== 1'b0 || busy !== 1'b0 || finish !== 1'b0 || timeout !== 1'b0 || runs_done !== 8'd0)
            $display("FAIL %s ctrl: go=%b busy=%b finish=%b timeout=%b runs=%0d, required all 0",
                     tag, dma_go, busy, finish, timeout, runs_done);
        else n_pass++;
        n_checks++;
        if (tim_last !== '0 || tim_min !== ONES || tim_max !== '0 || tim_sum !== '0)
            $display("FAIL %s stats: last=%0h min=%0h max=%0h sum=%0h, required 0/%0h/0/0",
                     tag, tim_last, tim_min, tim_max, tim_sum, ONES);
        else n_pass++;
    endtask

    task automatic test_reset();
        int go_base;
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        check_reset_values("reset");
        go_base = go_cnt;
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        step();
        step();
        check_reset_values("idle_done");
        n_checks++;
        if (go_cnt !== go_base) $display("FAIL idle_done go_count: got %0d, required %0d", go_cnt - go_base, 0);
        else n_pass++;
    endtask

    task automatic test_normal();
        set_dly(5, 3, 9, 7);
        run_check("normal", 1'b0);
    endtask

    task automatic test_restart();
        set_dly(2, 2, 2, 2);
        run_check("restart", 1'b0);
    endtask

    task automatic test_timeout();
        set_dly(6, 1000, 4, 4);
        run_check("timeout", 1'b0);
    endtask

    task automatic test_boundary();
        set_dly(100, 1, 100, 1);
        run_check("boundary", 1'b0);
    endtask

    task automatic test_ignore();
        set_dly(4, 8, 3, 11);
        run_check("ignore", 1'b1);
    endtask

    task automatic test_reset_mid();
        int budget;
        set_dly(10, 10, 10, 10);
        start = 1'b1;
        step();
        start = 1'b0;
        budget = 10;
        while (dma_go !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values("reset_mid");
        step();
        set_dly(12, 1, 6, 5);
        run_check("after_reset", 1'b0);
    endtask

    task automatic test_random();
        int v;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N_ITER; i++) begin
                v = $urandom_range(0, 15);
                if (v == 0)      dly[i] = 101 + $urandom_range(0, 20);
                else if (v == 1) dly[i] = 100;
                else if (v == 2) dly[i] = 1;
                else             dly[i] = $urandom_range(2, 30);
            end
            run_check($sformatf("random%0d", r), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dma_done = 1'b0;
        test_reset();
        test_normal();
        test_restart();
        test_timeout();
        test_boundary();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
